// File: rtl/vtg_pkg.sv
// Shared constants for the video timing generator configuration slice:
// staging indices, SVGA reset timing set, default widths and FSM states.
package vtg_pkg;

  localparam int HW_DEF = 11;
  localparam int VW_DEF = 10;

  localparam logic [2:0] CFG_HSBLK = 3'd0;
  localparam logic [2:0] CFG_HBBLK = 3'd1;
  localparam logic [2:0] CFG_HACT  = 3'd2;
  localparam logic [2:0] CFG_HFBLK = 3'd3;
  localparam logic [2:0] CFG_VSBLK = 3'd4;
  localparam logic [2:0] CFG_VBBLK = 3'd5;
  localparam logic [2:0] CFG_VACT  = 3'd6;
  localparam logic [2:0] CFG_VFBLK = 3'd7;

  localparam int SVGA_HSBLK = 127;
  localparam int SVGA_HBBLK = 215;
  localparam int SVGA_HACT  = 1015;
  localparam int SVGA_HFBLK = 1055;
  localparam int SVGA_VSBLK = 3;
  localparam int SVGA_VBBLK = 26;
  localparam int SVGA_VACT  = 626;
  localparam int SVGA_VFBLK = 627;

  typedef enum logic [1:0] {
    STOP     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } vtg_state_e;

endpackage

// File: rtl/vtg_cfg_check.sv
// Ordering validator for a timing set: each axis must be strictly increasing
// through sync, back porch, active and front porch boundaries.
module vtg_cfg_check
  import vtg_pkg::*;
#(
  parameter int HW = HW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic [HW-1:0] hsblk,
  input  logic [HW-1:0] hbblk,
  input  logic [HW-1:0] hact,
  input  logic [HW-1:0] hfblk,
  input  logic [VW-1:0] vsblk,
  input  logic [VW-1:0] vbblk,
  input  logic [VW-1:0] vact,
  input  logic [VW-1:0] vfblk,
  output logic          ok
);

  // Both axes must be strictly ordered for the set to be usable
  always_comb begin
    ok = (hsblk < hbblk) && (hbblk < hact) && (hact < hfblk) &&
         (vsblk < vbblk) && (vbblk < vact) && (vact < vfblk);
  end

endmodule

// File: rtl/vtg_cfg_ctrl.sv
// Configuration controller and start/stop sequencer for the timing generator.
// Staged values are validated on apply, held pending, and committed to the
// active bank only at a frame boundary (or right away while stopped).
module vtg_cfg_ctrl
  import vtg_pkg::*;
#(
  parameter int HW = HW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [HW-1:0] cfg_wdata,
  input  logic          cfg_apply,
  input  logic          run_req,
  input  logic          frame_end,
  output logic          vtg_en,
  output logic [HW-1:0] hsblk,
  output logic [HW-1:0] hbblk,
  output logic [HW-1:0] hact,
  output logic [HW-1:0] hfblk,
  output logic [VW-1:0] vsblk,
  output logic [VW-1:0] vbblk,
  output logic [VW-1:0] vact,
  output logic [VW-1:0] vfblk,
  output logic          apply_pend,
  output logic          apply_done,
  output logic          cfg_err
);

  localparam logic [3:0][HW-1:0] H_RST = {HW'(SVGA_HFBLK), HW'(SVGA_HACT),
                                          HW'(SVGA_HBBLK), HW'(SVGA_HSBLK)};
  localparam logic [3:0][VW-1:0] V_RST = {VW'(SVGA_VFBLK), VW'(SVGA_VACT),
                                          VW'(SVGA_VBBLK), VW'(SVGA_VSBLK)};

  logic [3:0][HW-1:0] stg_h_q, stg_h_d, pnd_h_q, pnd_h_d, act_h_q, act_h_d;
  logic [3:0][VW-1:0] stg_v_q, stg_v_d, pnd_v_q, pnd_v_d, act_v_q, act_v_d;
  logic               apply_pend_q, apply_pend_d;
  logic               apply_done_q, apply_done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               vtg_en_q, vtg_en_d;
  vtg_state_e         state_q, state_d;
  logic               set_ok;
  logic               commit;

  vtg_cfg_check #(.HW(HW), .VW(VW)) u_check (
    .hsblk (stg_h_q[0]),
    .hbblk (stg_h_q[1]),
    .hact  (stg_h_q[2]),
    .hfblk (stg_h_q[3]),
    .vsblk (stg_v_q[0]),
    .vbblk (stg_v_q[1]),
    .vact  (stg_v_q[2]),
    .vfblk (stg_v_q[3]),
    .ok    (set_ok)
  );

  // Run/stop sequencing: stopping waits for the frame to finish
  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP:     if (run_req) state_d = RUN;
      RUN:      if (!run_req) state_d = STOPPING;
      STOPPING: begin
        if (frame_end)    state_d = STOP;
        else if (run_req) state_d = RUN;
      end
      default:  state_d = STOP;
    endcase
    vtg_en_d = (state_d != STOP);
  end

  // Bank movement: staging writes, apply snapshot, boundary commit
  always_comb begin
    stg_h_d      = stg_h_q;
    stg_v_d      = stg_v_q;
    pnd_h_d      = pnd_h_q;
    pnd_v_d      = pnd_v_q;
    act_h_d      = act_h_q;
    act_v_d      = act_v_q;
    apply_pend_d = apply_pend_q;
    cfg_err_d    = cfg_err_q;
    commit       = apply_pend_q && ((state_q == STOP) || frame_end);

    if (cfg_we) begin
      if (!cfg_addr[2]) stg_h_d[cfg_addr[1:0]] = cfg_wdata;
      else              stg_v_d[cfg_addr[1:0]] = cfg_wdata[VW-1:0];
    end

    if (commit) begin
      act_h_d      = pnd_h_q;
      act_v_d      = pnd_v_q;
      apply_pend_d = 1'b0;
    end

    if (cfg_apply) begin
      if (set_ok) begin
        pnd_h_d      = stg_h_q;
        pnd_v_d      = stg_v_q;
        apply_pend_d = 1'b1;
        cfg_err_d    = 1'b0;
      end else begin
        cfg_err_d    = 1'b1;
      end
    end

    apply_done_d = commit;
  end

  // State and bank registers, all returning to the SVGA set on reset
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= STOP;
      vtg_en_q     <= 1'b0;
      stg_h_q      <= H_RST;
      stg_v_q      <= V_RST;
      pnd_h_q      <= H_RST;
      pnd_v_q      <= V_RST;
      act_h_q      <= H_RST;
      act_v_q      <= V_RST;
      apply_pend_q <= 1'b0;
      apply_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vtg_en_q     <= vtg_en_d;
      stg_h_q      <= stg_h_d;
      stg_v_q      <= stg_v_d;
      pnd_h_q      <= pnd_h_d;
      pnd_v_q      <= pnd_v_d;
      act_h_q      <= act_h_d;
      act_v_q      <= act_v_d;
      apply_pend_q <= apply_pend_d;
      apply_done_q <= apply_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign vtg_en     = vtg_en_q;
  assign hsblk      = act_h_q[0];
  assign hbblk      = act_h_q[1];
  assign hact       = act_h_q[2];
  assign hfblk      = act_h_q[3];
  assign vsblk      = act_v_q[0];
  assign vbblk      = act_v_q[1];
  assign vact       = act_v_q[2];
  assign vfblk      = act_v_q[3];
  assign apply_pend = apply_pend_q;
  assign apply_done = apply_done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_vtg_cfg_ctrl.sv
// Self-checking bench for vtg_cfg_ctrl: a transaction-level model of the
// three banks and run state is compared every cycle, plus literal spot checks.
module tb_vtg_cfg_ctrl;

  localparam int HW = 11;
  localparam int VW = 10;

  logic          clk = 1'b0;
  logic          rstb;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = 3'd0;
  logic [HW-1:0] cfg_wdata = '0;
  logic          cfg_apply = 1'b0;
  logic          run_req = 1'b0;
  logic          frame_end = 1'b0;
  logic          vtg_en;
  logic [HW-1:0] hsblk, hbblk, hact, hfblk;
  logic [VW-1:0] vsblk, vbblk, vact, vfblk;
  logic          apply_pend, apply_done, cfg_err;

  int passCount = 0;
  int checkCount = 0;

  vtg_cfg_ctrl #(.HW(HW), .VW(VW)) dut (
    .clk(clk), .rstb(rstb), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_apply(cfg_apply), .run_req(run_req),
    .frame_end(frame_end), .vtg_en(vtg_en),
    .hsblk(hsblk), .hbblk(hbblk), .hact(hact), .hfblk(hfblk),
    .vsblk(vsblk), .vbblk(vbblk), .vact(vact), .vfblk(vfblk),
    .apply_pend(apply_pend), .apply_done(apply_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: staging/pending/active as plain integer arrays
  int svga[8] = '{127, 215, 1015, 1055, 3, 26, 626, 627};
  int mStg[8] = '{127, 215, 1015, 1055, 3, 26, 626, 627};
  int mPnd[8] = '{127, 215, 1015, 1055, 3, 26, 626, 627};
  int mAct[8] = '{127, 215, 1015, 1055, 3, 26, 626, 627};
  bit mPend = 0, mDone = 0, mErr = 0;
  bit mRunning = 0, mDraining = 0;

  function automatic bit stagedOrdered();
    bit ok = 1'b1;
    for (int a = 0; a < 2; a++)
      for (int k = 0; k < 3; k++)
        if (mStg[a*4+k] >= mStg[a*4+k+1]) ok = 1'b0;
    return ok;
  endfunction

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mStg = svga; mPnd = svga; mAct = svga;
      mPend = 0; mDone = 0; mErr = 0; mRunning = 0; mDraining = 0;
    end else begin
      bit ok;
      bit boundary;
      ok = stagedOrdered();
      boundary = mPend && (!mRunning || frame_end);
      mDone = boundary;
      if (boundary) begin
        mAct = mPnd;
        mPend = 0;
      end
      if (cfg_apply) begin
        if (ok) begin
          mPnd = mStg;
          mPend = 1;
          mErr = 0;
        end else begin
          mErr = 1;
        end
      end
      if (cfg_we)
        mStg[cfg_addr] = (cfg_addr >= 3'd4) ? int'(cfg_wdata[VW-1:0]) : int'(cfg_wdata);
      if (!mRunning) begin
        if (run_req) mRunning = 1;
      end else if (!mDraining) begin
        if (!run_req) mDraining = 1;
      end else if (frame_end) begin
        mRunning = 0; mDraining = 0;
      end else if (run_req) begin
        mDraining = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    checkOutput("vtg_en", int'(vtg_en), int'(mRunning));
    checkOutput("hsblk", int'(hsblk), mAct[0]);
    checkOutput("hbblk", int'(hbblk), mAct[1]);
    checkOutput("hact", int'(hact), mAct[2]);
    checkOutput("hfblk", int'(hfblk), mAct[3]);
    checkOutput("vsblk", int'(vsblk), mAct[4]);
    checkOutput("vbblk", int'(vbblk), mAct[5]);
    checkOutput("vact", int'(vact), mAct[6]);
    checkOutput("vfblk", int'(vfblk), mAct[7]);
    checkOutput("apply_pend", int'(apply_pend), int'(mPend));
    checkOutput("apply_done", int'(apply_done), int'(mDone));
    checkOutput("cfg_err", int'(cfg_err), int'(mErr));
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit we, input int addr, input int data,
                               input bit apply, input bit fe);
    cfg_we = we;
    cfg_addr = 3'(addr);
    cfg_wdata = HW'(data);
    cfg_apply = apply;
    frame_end = fe;
    step();
    cfg_we = 0;
    cfg_apply = 0;
    frame_end = 0;
  endtask

  int wqvga[8] = '{40, 42, 522, 524, 9, 11, 283, 285};

  initial begin
    rstb = 1'b0;
    step();
    checkOutput("lit_rst_vtg_en", int'(vtg_en), 0);
    checkOutput("lit_rst_hsblk", int'(hsblk), 127);
    checkOutput("lit_rst_vfblk", int'(vfblk), 627);
    checkOutput("lit_rst_cfg_err", int'(cfg_err), 0);
    rstb = 1'b1;
    step();

    run_req = 1;
    step();
    checkOutput("lit_start_vtg_en", int'(vtg_en), 1);

    for (int i = 0; i < 8; i++) applyStimulus(1, i, wqvga[i], 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("lit_wq_pend", int'(apply_pend), 1);
    checkOutput("lit_wq_hold", int'(hact), 1015);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lit_wq_hold2", int'(hact), 1015);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_wq_hact", int'(hact), 522);
    checkOutput("lit_wq_vfblk", int'(vfblk), 285);
    checkOutput("lit_wq_done", int'(apply_done), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lit_wq_done_off", int'(apply_done), 0);

    applyStimulus(1, 1, 215, 0, 0);
    applyStimulus(1, 2, 200, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("lit_bad_err", int'(cfg_err), 1);
    checkOutput("lit_bad_pend", int'(apply_pend), 0);
    checkOutput("lit_bad_hact", int'(hact), 522);

    applyStimulus(1, 2, 300, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("lit_fix_err", int'(cfg_err), 0);
    applyStimulus(1, 2, 400, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_last_wins", int'(hact), 400);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lit_single_done", int'(apply_done), 0);

    applyStimulus(1, 2, 250, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 2, 350, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("lit_coinc_hact", int'(hact), 250);
    checkOutput("lit_coinc_pend", int'(apply_pend), 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_coinc_next", int'(hact), 350);

    applyStimulus(1, 2, 450, 1, 0);
    applyStimulus(1, 2, 480, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_prewrite", int'(hact), 450);

    run_req = 0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lit_drain_en", int'(vtg_en), 1);
    run_req = 1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lit_resume_en", int'(vtg_en), 1);
    run_req = 0;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_stop_en", int'(vtg_en), 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_stop_fe_ignored", int'(vtg_en), 0);

    applyStimulus(1, 2, 500, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("lit_stop_pend", int'(apply_pend), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lit_stop_commit", int'(hact), 500);

    run_req = 1;
    applyStimulus(1, 2, 460, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    run_req = 0;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lit_stopping_en", int'(vtg_en), 0);
    checkOutput("lit_stopping_hact", int'(hact), 460);

    applyStimulus(1, 6, 5, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("lit_verr", int'(cfg_err), 1);
    applyStimulus(1, 6, 283, 0, 0);

    run_req = 1;
    applyStimulus(1, 2, 470, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    #1 rstb = 1'b0;
    #1;
    checkOutput("lit_async_en", int'(vtg_en), 0);
    checkOutput("lit_async_hact", int'(hact), 1015);
    checkOutput("lit_async_pend", int'(apply_pend), 0);
    step();
    rstb = 1'b1;
    run_req = 0;
    repeat (3) step();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
